stall_ram: RTL and testbench
============================

STALL_RAM -- requirements
Module: stall_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: word-address bits used; depth is 2^ADDR_WIDTH words.
REQ-002 SHALL have parameter LATENCY, default 3: cycles from access accept to completion; legal range 1..15.
REQ-003 SHALL have port clk, in, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, in, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port cs, in, 1 bit: access request from the initiator, held high until stall=0.
REQ-006 SHALL have port we, in, 1 bit: 1 = write, 0 = read; sampled at accept.
REQ-007 SHALL have port addr, in, 32 bits: word address; only addr[ADDR_WIDTH-1:0] is used.
REQ-008 SHALL have port din, in, 32 bits: write data; sampled at accept.
REQ-009 SHALL have port dout, out, 32 bits: read data.
REQ-010 SHALL have port stall, out, 1 bit: access pending; the initiator holds its request while this is 1.

Function
REQ-011 SHALL implement states IDLE, WAIT and RESP.
REQ-012 stall SHALL be combinational: cs AND (state != RESP).
REQ-013 IDLE with cs=1 SHALL accept the request.
- Latch addr, we and din.
- Load the counter with LATENCY-1.
- Next state is RESP if LATENCY=1, otherwise WAIT.
REQ-014 WAIT with cs=1 SHALL behave as follows.
- Counter == 1: the memory operation executes on this edge and the next state is RESP.
- Otherwise: decrement the counter.
REQ-015 Accept cycle = cycle 0; RESP SHALL occur in cycle LATENCY, with stall=0 in that cycle.
REQ-016 A read SHALL register mem[latched addr] into dout on the edge entering RESP.
- dout holds that value until the next completed read.
REQ-017 A write SHALL commit latched din to mem[latched addr] on the edge entering RESP; dout is unchanged.
REQ-018 RESP SHALL go to IDLE unconditionally.
- A cs still high in the following IDLE cycle is a new access.
- Back-to-back period is LATENCY+1 cycles.
REQ-019 cs=0 sampled in WAIT SHALL abort the access.
- Next state is IDLE, no write occurs and dout is unchanged.
REQ-020 Changes on addr, we or din after accept SHALL be ignored; the latched values are used.
REQ-021 addr bits above ADDR_WIDTH-1 SHALL be ignored, so addresses wrap modulo depth.
REQ-022 A read of a location SHALL return the most recent completed write to it; memory is uninitialised until written.

Reset
REQ-023 rst=0 SHALL immediately force the following.
- state = IDLE, counter = 0, dout = 0.
- Latched addr, we and din cleared to 0.
REQ-024 Reset in the middle of an access SHALL discard it: no write commits, and stall follows REQ-012 once rst=1.
REQ-025 Memory array contents SHALL NOT be reset.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, WAIT, RESP), DATA_WIDTH=32 and LATENCY_MAX=15.
REQ-027 The array SHALL be one sub-module, stall_ram_array.
- Single-port synchronous RAM with clk, en, we, addr, din, dout.
- No reset.
- Instantiated once.

Verification (LATENCY=3, ADDR_WIDTH=10)
REQ-028 Write: cs=1, we=1, addr=5, din=0xDEADBEEF at cycle 0 -> stall=1 in cycles 0-2, stall=0 in cycle 3, mem[5]=0xDEADBEEF.
REQ-029 Read: cs=1, we=0, addr=5 at cycle 0 -> stall=1 in cycles 0-2; in cycle 3, stall=0 and dout=0xDEADBEEF.
REQ-030 Back-to-back: cs held high with reads of addr 1 then addr 2 -> completions in cycles 3 and 7, each dout matching the prior writes.
REQ-031 Abort: write with addr=7, din=0x12345678, then cs=0 in cycle 1 -> state IDLE in cycle 2; a later read of addr 7 returns the old value.
REQ-032 Wrap: write 0xA5A5A5A5 to addr 0x00000405 -> a read of addr 5 returns 0xA5A5A5A5.
REQ-033 Reset: rst=0 in cycle 1 of a write -> stall, counter and dout are 0 at once; the location is unchanged; LATENCY=1 re-run completes in cycle 1.

Source files
------------

// File: rtl/stall_ram_pkg.sv
// Shared definitions for the stall_ram block: state encoding, data width and
// the latency ceiling that sizes the wait counter.
package stall_ram_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_WIDTH   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/stall_ram_array.sv
// Single-port synchronous RAM without reset; the read register only updates
// on an enabled read, so it holds its value across writes.
module stall_ram_array
  import stall_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WIDTH      = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/stall_ram.sv
// Fixed-latency RAM front end: accepts one access at a time, stalls the
// initiator for LATENCY cycles and completes the memory operation on RESP entry.
//
// state | meaning
// IDLE  | no access in flight; cs=1 accepts and latches the request
// WAIT  | counting down; cs=0 aborts, counter==1 executes the access
// RESP  | access done this cycle, stall low, dout valid for reads
module stall_ram
  import stall_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  stall
);

  localparam int LAT = (LATENCY > LATENCY_MAX) ? LATENCY_MAX :
                       (LATENCY < 1)           ? 1 : LATENCY;
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LAT - 1);
  localparam logic                 ONE_CYCLE = (LAT == 1);

  state_e                  state, state_nxt;
  logic [CNT_WIDTH-1:0]    cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   din_q;
  logic                    rd_valid;

  logic                    accept, finish;
  logic                    ram_en, ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_din, ram_dout;
  logic                    unused_addr_hi;

  assign unused_addr_hi = ^addr[DATA_WIDTH-1:ADDR_WIDTH];

  assign accept = (state == IDLE) && cs;
  assign finish = ((state == WAIT) && cs && (cnt == CNT_WIDTH'(1))) ||
                  (accept && ONE_CYCLE);

  // A single-cycle access completes on the accept edge, before anything is latched.
  assign ram_we   = (state == IDLE) ? we : we_q;
  assign ram_addr = (state == IDLE) ? addr[ADDR_WIDTH-1:0] : addr_q;
  assign ram_din  = (state == IDLE) ? din : din_q;
  assign ram_en   = finish && rst;

  assign stall = rst && cs && (state != RESP);
  // The array register is not reset; rd_valid masks stale data after reset.
  assign dout  = rd_valid ? ram_dout : '0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (cs) begin
          state_nxt = ONE_CYCLE ? RESP : WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (!cs) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_WIDTH'(1)) begin
          state_nxt = RESP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_WIDTH'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      din_q    <= '0;
      rd_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q <= addr[ADDR_WIDTH-1:0];
        we_q   <= we;
        din_q  <= din;
      end
      if (ram_en && !ram_we) rd_valid <= 1'b1;
    end
  end

  stall_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (DATA_WIDTH)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

endmodule

// File: tb/tb_stall_ram.sv
// Directed bench for stall_ram: a LATENCY=3 instance driven from a vector
// table plus abort/reset sequences, and a LATENCY=1 instance for the short path.
module tb_stall_ram;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, we;
  logic [31:0] addr, din, dout;
  logic        stall;
  logic        cs1, we1;
  logic [31:0] addr1, din1, dout1;
  logic        stall1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  stall_ram #(.ADDR_WIDTH(10), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .stall(stall)
  );

  stall_ram #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .cs(cs1), .we(we1), .addr(addr1), .din(din1),
    .dout(dout1), .stall(stall1)
  );

  typedef struct {
    string       nm;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_dout;
    bit          keep;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Called just after a rising edge: this cycle is the accept cycle (cycle 0).
  task automatic access(input string nm, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_dout,
                        input bit keep);
    cs = 1'b1; we = w; addr = a; din = d;
    #1 chk({nm, " stall c0"}, 32'(stall), 32'd1);
    for (int c = 1; c < LAT; c++) begin
      @(posedge clk); #1;
      we = ~w; addr = ~a; din = ~d;
      #1 chk($sformatf("%s stall c%0d", nm, c), 32'(stall), 32'd1);
    end
    @(posedge clk); #1;
    #1 chk({nm, " stall resp"}, 32'(stall), 32'd0);
    chk({nm, " dout"}, dout, exp_dout);
    if (!keep) cs = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"wr5",    1'b1, 32'd5,     32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1] = '{"rd5",    1'b0, 32'd5,     32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{"wr1",    1'b1, 32'd1,     32'h11111111, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{"wr2",    1'b1, 32'd2,     32'h22222222, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{"b2b_rd1",1'b0, 32'd1,     32'h0,        32'h11111111, 1'b1};
    vecs[5] = '{"b2b_rd2",1'b0, 32'd2,     32'h0,        32'h22222222, 1'b0};
    vecs[6] = '{"wr405",  1'b1, 32'h405,   32'hA5A5A5A5, 32'h22222222, 1'b0};
    vecs[7] = '{"wrap_rd5",1'b0,32'd5,     32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[8] = '{"wr7",    1'b1, 32'd7,     32'hCAFEF00D, 32'hA5A5A5A5, 1'b0};
    vecs[9] = '{"rd407",  1'b0, 32'h407,   32'h0,        32'hCAFEF00D, 1'b0};

    rst = 1'b0; cs = 1'b1; we = 1'b0; addr = '0; din = '0;
    cs1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset dout", dout, 32'd0);
    cs = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      access(vecs[i].nm, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_dout, vecs[i].keep);

    // Abort: write to 7 withdrawn in cycle 1; the next cycle must be IDLE.
    cs = 1'b1; we = 1'b1; addr = 32'd7; din = 32'h12345678;
    #1 chk("abort stall c0", 32'(stall), 32'd1);
    @(posedge clk); #1;
    chk("abort stall c1", 32'(stall), 32'd1);
    cs = 1'b0;
    #1 chk("abort stall drop", 32'(stall), 32'd0);
    @(posedge clk); #1;
    access("abort_rd7", 1'b0, 32'd7, 32'h0, 32'hCAFEF00D, 1'b0);

    // Reset in cycle 1 of a write to 5.
    cs = 1'b1; we = 1'b1; addr = 32'd5; din = 32'h0BADF00D;
    #1 chk("rstw stall c0", 32'(stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("rstw stall", 32'(stall), 32'd0);
    chk("rstw dout", dout, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; cs = 1'b0;
    #1 chk("rstw dout after", dout, 32'd0);
    @(posedge clk); #1;
    access("rstw_rd5", 1'b0, 32'd5, 32'h0, 32'hA5A5A5A5, 1'b0);

    // LATENCY=1 instance: completion in cycle 1.
    cs1 = 1'b1; we1 = 1'b1; addr1 = 32'd3; din1 = 32'h13579BDF;
    #1 chk("l1 wr stall c0", 32'(stall1), 32'd1);
    @(posedge clk); #1;
    chk("l1 wr stall c1", 32'(stall1), 32'd0);
    chk("l1 wr dout", dout1, 32'd0);
    we1 = 1'b0;
    @(posedge clk); #1;
    chk("l1 rd stall c0", 32'(stall1), 32'd1);
    @(posedge clk); #1;
    chk("l1 rd stall c1", 32'(stall1), 32'd0);
    chk("l1 rd dout", dout1, 32'h13579BDF);
    cs1 = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
